game_flow_ctrl: RTL and testbench

Parametrised game-flow controller for the Pac-Man top level: owns the INIT/PLAY/DYING/CLEAR/OVER state machine, lives, level and pill bookkeeping, and pac-ghost collision resolution for any number of ghosts. New behaviour over the previous hard-wired two-ghost flow: frightened (power-pill) mode with per-ghost eat pulses, level-clear and advance, and a configurable starting lives and delays. It sits beside `pacman_loc_ctrl`, the ghost AI and `map_RAM_writer`, and drives their resets and enables.

---
 rtl/game_flow_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the Pac-Man top level.
// Owns the INIT/PLAY/DYING/CLEAR/OVER sequence, lives/level/pill bookkeeping,
// frightened (power-pill) mode and pac-ghost collision resolution for
// NUM_GHOSTS ghosts. Control outputs are decoded from the registered state;
// counters and event pulses are registered.
module game_flow_ctrl #(
    parameter int NUM_GHOSTS    = 2,
    parameter int X_W           = 6,
    parameter int Y_W           = 5,
    parameter int START_LIVES   = 3,
    parameter int TOTAL_PILLS   = 240,
    parameter int RESUME_CYCLES = 250000000,
    parameter int FRIGHT_CYCLES = 350000000,
    localparam int PILL_W       = $clog2(TOTAL_PILLS + 1)
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [X_W-1:0]            pac_x,
    input  logic [Y_W-1:0]            pac_y,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
    input  logic                      pill_eaten,
    input  logic                      power_eaten,
    output logic                      sprite_reset,
    output logic                      map_wr_reset,
    output logic                      ghost_enable,
    output logic                      frightened,
    output logic [NUM_GHOSTS-1:0]     ghost_eaten,
    output logic                      death,
    output logic [2:0]                lives,
    output logic [3:0]                level,
    output logic [PILL_W-1:0]         pills_left,
    output logic [2:0]                state
);

    localparam int DLY_W = (RESUME_CYCLES > 1) ? $clog2(RESUME_CYCLES) : 1;
    localparam int FR_W  = (FRIGHT_CYCLES > 1) ? $clog2(FRIGHT_CYCLES) : 1;

    localparam logic [DLY_W-1:0]  DLY_LOAD   = DLY_W'(RESUME_CYCLES - 1);
    localparam logic [FR_W-1:0]   FR_LOAD    = FR_W'(FRIGHT_CYCLES - 1);
    localparam logic [PILL_W-1:0] PILL_FULL  = PILL_W'(TOTAL_PILLS);
    localparam logic [PILL_W-1:0] PILL_ONE   = PILL_W'(1);
    localparam logic [2:0]        LIVES_INIT = 3'(START_LIVES);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_DYING = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            lives_q, lives_d;
    logic [3:0]            level_q, level_d;
    logic [PILL_W-1:0]     pills_q, pills_d;
    logic                  fright_q, fright_d;
    logic [FR_W-1:0]       fcnt_q, fcnt_d;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic [NUM_GHOSTS-1:0] prev_q, prev_d;
    logic [NUM_GHOSTS-1:0] ge_q, ge_d;
    logic                  death_q, death_d;
    logic [NUM_GHOSTS-1:0] coll_s;
    logic [NUM_GHOSTS-1:0] hit_s;

    // Per-ghost tile match and its rising edge (prev_q is only kept in PLAY)
    always_comb begin
        coll_s = {NUM_GHOSTS{1'b0}};
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            coll_s[i] = (ghost_x[i*X_W +: X_W] == pac_x) &&
                        (ghost_y[i*Y_W +: Y_W] == pac_y);
        end
        hit_s = coll_s & ~prev_q;
    end

    // Next-state, bookkeeping and pulse generation
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        level_d  = level_q;
        pills_d  = pills_q;
        fright_d = fright_q;
        fcnt_d   = fcnt_q;
        dly_d    = dly_q;
        prev_d   = {NUM_GHOSTS{1'b0}};
        ge_d     = {NUM_GHOSTS{1'b0}};
        death_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                lives_d  = LIVES_INIT;
                level_d  = 4'd1;
                pills_d  = PILL_FULL;
                fright_d = 1'b0;
                fcnt_d   = {FR_W{1'b0}};
                if (start) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_PLAY: begin
                prev_d = coll_s;
                if (pill_eaten && (pills_q == PILL_ONE)) begin
                    // Clearing the level wins over any simultaneous collision
                    pills_d  = {PILL_W{1'b0}};
                    fright_d = 1'b0;
                    fcnt_d   = {FR_W{1'b0}};
                    dly_d    = DLY_LOAD;
                    state_d  = ST_CLEAR;
                end else if ((|hit_s) && !fright_q) begin
                    death_d  = 1'b1;
                    lives_d  = lives_q - 3'd1;
                    fright_d = 1'b0;
                    fcnt_d   = {FR_W{1'b0}};
                    dly_d    = DLY_LOAD;
                    if (lives_q == 3'd1) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_DYING;
                    end
                end else begin
                    // Any hit reaching here happens while frightened
                    ge_d = hit_s;
                    if (pill_eaten && (pills_q != {PILL_W{1'b0}})) begin
                        pills_d = pills_q - PILL_ONE;
                    end else begin
                        pills_d = pills_q;
                    end
                    if (power_eaten) begin
                        fright_d = 1'b1;
                        fcnt_d   = FR_LOAD;
                    end else if (fright_q) begin
                        if (fcnt_q == {FR_W{1'b0}}) begin
                            fright_d = 1'b0;
                        end else begin
                            fcnt_d = fcnt_q - {{(FR_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        fright_d = 1'b0;
                    end
                end
            end
            ST_DYING: begin
                if (dly_q == {DLY_W{1'b0}}) begin
                    state_d = ST_PLAY;
                end else begin
                    dly_d = dly_q - {{(DLY_W-1){1'b0}}, 1'b1};
                end
            end
            ST_CLEAR: begin
                if (dly_q == {DLY_W{1'b0}}) begin
                    state_d = ST_PLAY;
                    pills_d = PILL_FULL;
                    if (level_q != 4'd15) begin
                        level_d = level_q + 4'd1;
                    end else begin
                        level_d = level_q;
                    end
                end else begin
                    dly_d = dly_q - {{(DLY_W-1){1'b0}}, 1'b1};
                end
            end
            ST_OVER: begin
                if (!start) begin
                    // Reload on the way out so INIT already shows fresh values
                    state_d = ST_INIT;
                    lives_d = LIVES_INIT;
                    level_d = 4'd1;
                    pills_d = PILL_FULL;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, counter and pulse registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            lives_q  <= LIVES_INIT;
            level_q  <= 4'd1;
            pills_q  <= PILL_FULL;
            fright_q <= 1'b0;
            fcnt_q   <= {FR_W{1'b0}};
            dly_q    <= {DLY_W{1'b0}};
            prev_q   <= {NUM_GHOSTS{1'b0}};
            ge_q     <= {NUM_GHOSTS{1'b0}};
            death_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            pills_q  <= pills_d;
            fright_q <= fright_d;
            fcnt_q   <= fcnt_d;
            dly_q    <= dly_d;
            prev_q   <= prev_d;
            ge_q     <= ge_d;
            death_q  <= death_d;
        end
    end

    // Control outputs decoded from the registered state
    always_comb begin
        sprite_reset = 1'b1;
        map_wr_reset = 1'b1;
        ghost_enable = 1'b0;
        case (state_q)
            ST_INIT:  begin sprite_reset = 1'b1; map_wr_reset = 1'b1; ghost_enable = 1'b0; end
            ST_PLAY:  begin sprite_reset = 1'b0; map_wr_reset = 1'b0; ghost_enable = 1'b1; end
            ST_DYING: begin sprite_reset = 1'b1; map_wr_reset = 1'b0; ghost_enable = 1'b0; end
            ST_CLEAR: begin sprite_reset = 1'b1; map_wr_reset = 1'b1; ghost_enable = 1'b0; end
            ST_OVER:  begin sprite_reset = 1'b0; map_wr_reset = 1'b1; ghost_enable = 1'b0; end
            default:  begin sprite_reset = 1'b1; map_wr_reset = 1'b1; ghost_enable = 1'b0; end
        endcase
    end

    assign frightened  = fright_q;
    assign ghost_eaten = ge_q;
    assign death       = death_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign pills_left  = pills_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: three ghosts, short delays, three pills.
module tb_game_flow_ctrl;

    localparam int NG = 3;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int PW = $clog2(3 + 1);

    logic            clk_s = 1'b0;
    logic            rst_n_s;
    logic            start_s;
    logic [XW-1:0]   pac_x_s;
    logic [YW-1:0]   pac_y_s;
    logic [NG*XW-1:0] ghost_x_s;
    logic [NG*YW-1:0] ghost_y_s;
    logic            pill_s;
    logic            power_s;
    logic            sprite_reset_s;
    logic            map_wr_reset_s;
    logic            ghost_enable_s;
    logic            frightened_s;
    logic [NG-1:0]   ghost_eaten_s;
    logic            death_s;
    logic [2:0]      lives_s;
    logic [3:0]      level_s;
    logic [PW-1:0]   pills_left_s;
    logic [2:0]      state_s;

    int n_vec = 0;
    int n_bad = 0;

    game_flow_ctrl #(
        .NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .START_LIVES(3),
        .TOTAL_PILLS(3), .RESUME_CYCLES(4), .FRIGHT_CYCLES(8)
    ) dut (
        .CLOCK_50(clk_s), .reset_n(rst_n_s), .start(start_s),
        .pac_x(pac_x_s), .pac_y(pac_y_s),
        .ghost_x(ghost_x_s), .ghost_y(ghost_y_s),
        .pill_eaten(pill_s), .power_eaten(power_s),
        .sprite_reset(sprite_reset_s), .map_wr_reset(map_wr_reset_s),
        .ghost_enable(ghost_enable_s), .frightened(frightened_s),
        .ghost_eaten(ghost_eaten_s), .death(death_s),
        .lives(lives_s), .level(level_s), .pills_left(pills_left_s),
        .state(state_s)
    );

    // Free-running clock
    always #5 clk_s = ~clk_s;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_s);
            #1;
        end
    endtask

    // Place ghost g on pacman (on=1) or back at its home tile (g+1, g+1)
    task automatic put_ghost(input int g, input bit on);
        if (on) begin
            ghost_x_s[g*XW +: XW] = pac_x_s;
            ghost_y_s[g*YW +: YW] = pac_y_s;
        end else begin
            ghost_x_s[g*XW +: XW] = XW'(g + 1);
            ghost_y_s[g*YW +: YW] = YW'(g + 1);
        end
    endtask

    initial begin
        rst_n_s = 1'b0;
        start_s = 1'b0;
        pill_s  = 1'b0;
        power_s = 1'b0;
        pac_x_s = 6'd10;
        pac_y_s = 5'd10;
        ghost_x_s = '0;
        ghost_y_s = '0;
        for (int g = 0; g < NG; g++) put_ghost(g, 1'b0);
        step(2);

        // Reset values
        chk("rst_state", state_s, 0);
        chk("rst_sprite", sprite_reset_s, 1);
        chk("rst_map", map_wr_reset_s, 1);
        chk("rst_genable", ghost_enable_s, 0);
        chk("rst_lives", lives_s, 3);
        chk("rst_level", level_s, 1);
        chk("rst_pills", pills_left_s, 3);
        chk("rst_fright", frightened_s, 0);

        // Start the game
        rst_n_s = 1'b1;
        start_s = 1'b1;
        step(1);
        chk("play_state", state_s, 1);
        chk("play_genable", ghost_enable_s, 1);
        chk("play_sprite", sprite_reset_s, 0);

        // Ghost 2 kills pacman; collision held through DYING
        put_ghost(2, 1'b1);
        step(1);
        chk("d1_death", death_s, 1);
        chk("d1_lives", lives_s, 2);
        chk("d1_state", state_s, 2);
        chk("d1_map", map_wr_reset_s, 0);
        chk("d1_sprite", sprite_reset_s, 1);
        step(1);
        chk("d1_pulse_end", death_s, 0);
        put_ghost(2, 1'b0);
        step(2);
        chk("d1_still_dying", state_s, 2);
        step(1);
        chk("d1_resume", state_s, 1);

        // Second death
        put_ghost(1, 1'b1);
        step(1);
        chk("d2_lives", lives_s, 1);
        put_ghost(1, 1'b0);
        step(4);
        chk("d2_resume", state_s, 1);

        // Third death ends the game
        put_ghost(0, 1'b1);
        step(1);
        chk("d3_death", death_s, 1);
        chk("over_state", state_s, 4);
        chk("over_lives", lives_s, 0);
        chk("over_map", map_wr_reset_s, 1);
        chk("over_sprite", sprite_reset_s, 0);
        put_ghost(0, 1'b0);
        step(2);
        chk("over_hold", state_s, 4);
        start_s = 1'b0;
        step(1);
        chk("reinit_state", state_s, 0);
        chk("reinit_lives", lives_s, 3);
        start_s = 1'b1;
        step(1);
        chk("replay_state", state_s, 1);

        // Power pill, then ghosts 0 and 1 collide together for 5 cycles
        pill_s = 1'b1; power_s = 1'b1;
        step(1);                                  // E0
        pill_s = 1'b0; power_s = 1'b0;
        chk("fr_on", frightened_s, 1);
        chk("fr_pills", pills_left_s, 2);
        put_ghost(0, 1'b1);
        put_ghost(1, 1'b1);
        step(1);                                  // E1
        chk("fr_eat", ghost_eaten_s, 3);
        chk("fr_no_death", death_s, 0);
        for (int e = 2; e <= 5; e++) begin
            step(1);
            chk("fr_eat_once", ghost_eaten_s, 0);
        end
        chk("fr_lives", lives_s, 3);
        chk("fr_e5", frightened_s, 1);
        put_ghost(0, 1'b0);
        put_ghost(1, 1'b0);
        pill_s = 1'b1; power_s = 1'b1;
        step(1);                                  // E6: timer reload
        pill_s = 1'b0; power_s = 1'b0;
        chk("fr2_pills", pills_left_s, 1);
        step(7);                                  // E13
        chk("fr2_e13", frightened_s, 1);
        step(1);                                  // E14
        chk("fr2_e14", frightened_s, 0);

        // Last pill clears level 1
        pill_s = 1'b1;
        step(1);
        pill_s = 1'b0;
        chk("c1_state", state_s, 3);
        chk("c1_pills", pills_left_s, 0);
        chk("c1_map", map_wr_reset_s, 1);
        step(3);
        chk("c1_hold", state_s, 3);
        step(1);
        chk("c1_resume", state_s, 1);
        chk("c1_level", level_s, 2);
        chk("c1_refill", pills_left_s, 3);

        // Three consecutive pill pulses clear level 2
        pill_s = 1'b1;
        step(3);
        pill_s = 1'b0;
        chk("c2_state", state_s, 3);
        step(4);
        chk("c2_level", level_s, 3);
        chk("c2_refill", pills_left_s, 3);

        // Last pill together with a lethal collision: clear wins
        pill_s = 1'b1;
        step(2);
        put_ghost(2, 1'b1);
        step(1);
        pill_s = 1'b0;
        put_ghost(2, 1'b0);
        chk("cx_state", state_s, 3);
        chk("cx_death", death_s, 0);
        chk("cx_lives", lives_s, 3);
        step(4);
        chk("cx_level", level_s, 4);

        // Reset in the middle of DYING
        put_ghost(2, 1'b1);
        step(1);
        put_ghost(2, 1'b0);
        chk("rd_dying", state_s, 2);
        step(1);
        rst_n_s = 1'b0;
        #1;
        chk("rd_state", state_s, 0);
        chk("rd_lives", lives_s, 3);
        chk("rd_level", level_s, 1);
        chk("rd_pills", pills_left_s, 3);
        chk("rd_sprite", sprite_reset_s, 1);
        chk("rd_genable", ghost_enable_s, 0);
        chk("rd_death", death_s, 0);
        step(2);
        chk("rd_held", state_s, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
